gray_to_rgb: RTL and testbench
==============================

GRAY_TO_RGB -- requirements
Module: gray_to_rgb

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 iCLK  input  1  pixel clock, all state on rising edge.
REQ-004 iRST  input  1  reset, asynchronous, active-low.
REQ-005 iDVAL  input  1  gray pixel valid strobe.
REQ-006 iDATA  input  10  unsigned gray pixel.
REQ-007 iVS  input  1  frame resync, active-high.
REQ-008 iMODE  input  2  colour mode: 0 gray, 1 invert, 2 heat, 3 threshold.
REQ-009 iTHR  input  10  threshold level for mode 3.
REQ-010 iMARK_EN  input  1  enable crosshair overlay.
REQ-011 iCX, iCY  input  10 each  crosshair column and row.
REQ-012 oDVAL  output  1  RGB pixel valid.
REQ-013 oRed, oGreen, oBlue  output  10 each  RGB pixel.
REQ-014 oSOF  output  1  high with oDVAL for pixel (0,0) of each frame.

Function
REQ-015 Column counter SHALL increment on each iDVAL beat, wrap H_ACTIVE-1 -> 0 and advance the row counter.
REQ-016 Row counter SHALL wrap V_ACTIVE-1 -> 0 on the last beat of a frame.
REQ-017 iVS high SHALL force the current beat's coordinates to (0,0); an iDVAL beat in the same cycle SHALL be processed as pixel (0,0) and counters SHALL advance to (1,0); without iDVAL, counters SHALL become (0,0).
REQ-018 iMODE, iTHR, iMARK_EN, iCX and iCY SHALL be captured into shadow registers only on a beat at (0,0); all other pixels SHALL use shadow values, never live inputs.
REQ-019 The beat at (0,0) SHALL use the newly captured values.
REQ-020 Pipeline latency SHALL be exactly 2 cycles, iDVAL -> oDVAL, with no back-pressure.
REQ-021 Stage 1 SHALL register gray, coordinates, marker hit and SOF flag; stage 2 SHALL register the colour-mapped RGB.
REQ-022 Gaps (iDVAL low) SHALL be allowed on any cycle; oDVAL SHALL then be low and the RGB outputs SHALL hold their last values.
REQ-023 Mode 0: R=G=B=g.
REQ-024 Mode 1: R=G=B=1023-g.
REQ-025 Mode 2, g[9]=0: R=0, G={g[8:0],0}, B=1022-{g[8:0],0}.
REQ-026 Mode 2, g[9]=1: R={g[8:0],0}, G=1022-{g[8:0],0}, B=0.
REQ-027 Mode 3: R=G=B=1023 when g>=thr, otherwise 0.
REQ-028 All arithmetic SHALL be 10-bit unsigned with no overflow.
REQ-029 When shadow mark_en=1 and (col==cx or row==cy), output SHALL be R=1023, G=0, B=0, overriding the mode.
REQ-030 cx>=H_ACTIVE or cy>=V_ACTIVE SHALL suppress that line of the crosshair.
REQ-031 oSOF SHALL be a single-cycle pulse aligned with the oDVAL of pixel (0,0).

Reset
REQ-032 Reset asserted SHALL immediately clear oDVAL, oSOF, oRed, oGreen, oBlue, both pipeline stages and the counters to 0.
REQ-033 Reset SHALL set shadow mode=0, thr=512, mark_en=0, cx=cy=0.
REQ-034 After reset mid-frame, the first iDVAL beat SHALL be pixel (0,0) and SHALL load the shadows.

Structure
REQ-035 Package gray_to_rgb_pkg SHALL hold the mode encoding, PIX_MAX=1023, the marker colour constants and the reset threshold 512.
REQ-036 The colour map SHALL be a combinational sub-module gray_to_rgb_cmap (inputs g, mode, thr; outputs R, G, B), registered by the parent.

Verification
REQ-037 Mode 0, g=300 at (5,5) -> 2 cycles later R=G=B=300, oDVAL=1.
REQ-038 Mode 2, g=256 -> R=0, G=512, B=510; g=768 -> R=512, G=510, B=0.
REQ-039 Mode 3, thr=512: g=511 -> 0,0,0; g=512 -> 1023,1023,1023.
REQ-040 Change iMODE 0->1 mid-frame, g=100 -> output stays 100 until the next (0,0) beat, then 923 with oSOF=1.
REQ-041 mark_en=1, cx=10, cy=20, H_ACTIVE=16, V_ACTIVE=24 -> pixels at col 10 or row 20 are (1023,0,0), all others are mode-mapped.
REQ-042 iVS with iDVAL at (7,3) -> that beat is output with oSOF=1; next beat is (1,0).
REQ-043 Reset asserted between beats at (4,2) -> outputs 0 immediately; the first beat after release loads the shadows and gives oSOF=1.

Source files
------------

// File: rtl/gray_to_rgb_pkg.sv
// ============================================================================
// Module      : gray_to_rgb_pkg
// Description : Shared types and constants for the gray_to_rgb colour mapper.
//               Holds the colour-mode encoding, the pixel full-scale value,
//               the crosshair marker colour, the reset threshold and the
//               frame-shadowed configuration record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_to_rgb_pkg;

    localparam int         PIX_W      = 10;
    localparam logic [9:0] PIX_MAX    = 10'd1023;
    localparam logic [9:0] THR_RESET  = 10'd512;

    // Crosshair overlay colour (pure red)
    localparam logic [9:0] MARK_RED   = 10'd1023;
    localparam logic [9:0] MARK_GREEN = 10'd0;
    localparam logic [9:0] MARK_BLUE  = 10'd0;

    typedef enum logic [1:0] {
        MODE_GRAY   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_HEAT   = 2'd2,
        MODE_THRESH = 2'd3
    } mode_e;

    // Per-frame configuration, latched only on the (0,0) beat
    typedef struct packed {
        mode_e      mode;
        logic [9:0] thr;
        logic       mark_en;
        logic [9:0] cx;
        logic [9:0] cy;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        mode:    MODE_GRAY,
        thr:     THR_RESET,
        mark_en: 1'b0,
        cx:      10'd0,
        cy:      10'd0
    };

endpackage

`default_nettype wire

// File: rtl/gray_to_rgb_cmap.sv
// ============================================================================
// Module      : gray_to_rgb_cmap
// Description : Purely combinational gray -> RGB colour map.
//   g     in   10  unsigned gray level
//   mode  in    2  0 gray, 1 invert, 2 heat, 3 threshold
//   thr   in   10  threshold level for mode 3
//   R/G/B out  10  mapped colour components
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_to_rgb_cmap
    import gray_to_rgb_pkg::*;
(
    input  logic [9:0] g,
    input  logic [1:0] mode,
    input  logic [9:0] thr,
    output logic [9:0] R,
    output logic [9:0] G,
    output logic [9:0] B
);

    // Heat ramp: the low 9 bits doubled give a 0..1022 ramp within each half,
    // so 1022-heat can never underflow.
    localparam logic [9:0] HEAT_TOP = PIX_MAX - 10'd1;

    logic [9:0] heat;
    logic [9:0] inv;
    logic [9:0] bin;

    always_comb begin
        heat = {g[8:0], 1'b0};
        inv  = PIX_MAX - g;
        bin  = (g >= thr) ? PIX_MAX : 10'd0;
        R    = g;
        G    = g;
        B    = g;
        case (mode_e'(mode))
            MODE_GRAY: begin
                R = g;
                G = g;
                B = g;
            end
            MODE_INVERT: begin
                R = inv;
                G = inv;
                B = inv;
            end
            MODE_HEAT: begin
                if (!g[9]) begin
                    R = 10'd0;
                    G = heat;
                    B = HEAT_TOP - heat;
                end else begin
                    R = heat;
                    G = HEAT_TOP - heat;
                    B = 10'd0;
                end
            end
            MODE_THRESH: begin
                R = bin;
                G = bin;
                B = bin;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gray_to_rgb.sv
// ============================================================================
// Module      : gray_to_rgb
// Description : Streaming gray -> RGB converter with per-frame configuration
//               shadowing and an optional crosshair overlay. Two-stage
//               pipeline, fixed 2-cycle latency, no back-pressure.
//   iCLK/iRST          pixel clock / async active-low reset
//   iDVAL, iDATA       gray pixel strobe and value
//   iVS                frame resync (forces the current beat to (0,0))
//   iMODE, iTHR        colour mode and threshold (shadowed per frame)
//   iMARK_EN, iCX, iCY crosshair enable and position (shadowed per frame)
//   oDVAL, oRed/oGreen/oBlue, oSOF   RGB pixel, valid, start-of-frame
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_to_rgb
    import gray_to_rgb_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iDVAL,
    input  logic [9:0] iDATA,
    input  logic       iVS,
    input  logic [1:0] iMODE,
    input  logic [9:0] iTHR,
    input  logic       iMARK_EN,
    input  logic [9:0] iCX,
    input  logic [9:0] iCY,
    output logic       oDVAL,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic       oSOF
);

    localparam int               COL_W    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int               ROW_W    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
    localparam logic [31:0]      H_LIM    = 32'(H_ACTIVE);
    localparam logic [31:0]      V_LIM    = 32'(V_ACTIVE);

    // Position and frame configuration
    logic [COL_W-1:0] col_q, col_d, cur_col;
    logic [ROW_W-1:0] row_q, row_d, cur_row;
    cfg_t             cfg_q, cfg_d, cfg_live, cfg_eff;
    logic             at_origin;
    logic             hit_col, hit_row;

    // Stage 1: gray, mark hit, SOF, plus the config that the colour map needs
    logic       s1_vld_q,  s1_vld_d;
    logic       s1_sof_q,  s1_sof_d;
    logic       s1_hit_q,  s1_hit_d;
    logic [9:0] s1_gray_q, s1_gray_d;
    logic [9:0] s1_thr_q,  s1_thr_d;
    mode_e      s1_mode_q, s1_mode_d;

    // Stage 2: mapped RGB
    logic       dval_q,  dval_d;
    logic       sof_q,   sof_d;
    logic [9:0] red_q,   red_d;
    logic [9:0] green_q, green_d;
    logic [9:0] blue_q,  blue_d;
    logic [9:0] map_r, map_g, map_b;

    always_comb begin
        // iVS relocates the current beat to the frame origin
        cur_col   = iVS ? '0 : col_q;
        cur_row   = iVS ? '0 : row_q;
        at_origin = (cur_col == '0) && (cur_row == '0);

        cfg_live = '{
            mode:    mode_e'(iMODE),
            thr:     iTHR,
            mark_en: iMARK_EN,
            cx:      iCX,
            cy:      iCY
        };

        // The origin beat itself already sees the freshly captured config
        cfg_eff = (iDVAL && at_origin) ? cfg_live : cfg_q;
        cfg_d   = cfg_eff;

        // Out-of-range crosshair coordinates disable that line entirely
        hit_col = cfg_eff.mark_en && (32'(cfg_eff.cx) < H_LIM)
                  && (32'(cur_col) == 32'(cfg_eff.cx));
        hit_row = cfg_eff.mark_en && (32'(cfg_eff.cy) < V_LIM)
                  && (32'(cur_row) == 32'(cfg_eff.cy));

        col_d = col_q;
        row_d = row_q;
        if (iDVAL) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
        end else if (iVS) begin
            col_d = '0;
            row_d = '0;
        end

        s1_vld_d  = iDVAL;
        s1_sof_d  = s1_sof_q;
        s1_hit_d  = s1_hit_q;
        s1_gray_d = s1_gray_q;
        s1_thr_d  = s1_thr_q;
        s1_mode_d = s1_mode_q;
        if (iDVAL) begin
            s1_sof_d  = at_origin;
            s1_hit_d  = hit_col || hit_row;
            s1_gray_d = iDATA;
            s1_thr_d  = cfg_eff.thr;
            s1_mode_d = cfg_eff.mode;
        end
    end

    gray_to_rgb_cmap u_cmap (
        .g    (s1_gray_q),
        .mode (s1_mode_q),
        .thr  (s1_thr_q),
        .R    (map_r),
        .G    (map_g),
        .B    (map_b)
    );

    always_comb begin
        dval_d  = s1_vld_q;
        sof_d   = s1_vld_q && s1_sof_q;
        red_d   = red_q;
        green_d = green_q;
        blue_d  = blue_q;
        if (s1_vld_q) begin
            red_d   = s1_hit_q ? MARK_RED   : map_r;
            green_d = s1_hit_q ? MARK_GREEN : map_g;
            blue_d  = s1_hit_q ? MARK_BLUE  : map_b;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col_q     <= '0;
            row_q     <= '0;
            cfg_q     <= CFG_RESET;
            s1_vld_q  <= 1'b0;
            s1_sof_q  <= 1'b0;
            s1_hit_q  <= 1'b0;
            s1_gray_q <= '0;
            s1_thr_q  <= '0;
            s1_mode_q <= MODE_GRAY;
            dval_q    <= 1'b0;
            sof_q     <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            cfg_q     <= cfg_d;
            s1_vld_q  <= s1_vld_d;
            s1_sof_q  <= s1_sof_d;
            s1_hit_q  <= s1_hit_d;
            s1_gray_q <= s1_gray_d;
            s1_thr_q  <= s1_thr_d;
            s1_mode_q <= s1_mode_d;
            dval_q    <= dval_d;
            sof_q     <= sof_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign oDVAL  = dval_q;
    assign oSOF   = sof_q;
    assign oRed   = red_q;
    assign oGreen = green_q;
    assign oBlue  = blue_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_to_rgb.sv
// ============================================================================
// Module      : tb_gray_to_rgb
// Description : Self-checking bench for gray_to_rgb (16x24 frame). A frame-
//               level reference model predicts every output cycle; directed
//               beats carry hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_to_rgb;

    localparam int H = 16;
    localparam int V = 24;

    logic       iCLK = 1'b0;
    logic       iRST = 1'b0;
    logic       iDVAL = 1'b0;
    logic [9:0] iDATA = '0;
    logic       iVS = 1'b0;
    logic [1:0] iMODE = '0;
    logic [9:0] iTHR = 10'd512;
    logic       iMARK_EN = 1'b0;
    logic [9:0] iCX = '0;
    logic [9:0] iCY = '0;
    logic       oDVAL, oSOF;
    logic [9:0] oRed, oGreen, oBlue;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 iCLK = ~iCLK;

    gray_to_rgb #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iDVAL    (iDVAL),
        .iDATA    (iDATA),
        .iVS      (iVS),
        .iMODE    (iMODE),
        .iTHR     (iTHR),
        .iMARK_EN (iMARK_EN),
        .iCX      (iCX),
        .iCY      (iCY),
        .oDVAL    (oDVAL),
        .oRed     (oRed),
        .oGreen   (oGreen),
        .oBlue    (oBlue),
        .oSOF     (oSOF)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        bit v;
        bit sof;
        int r;
        int g;
        int b;
    } pix_t;

    pix_t p1 = '0;
    pix_t p2 = '0;
    int m_col = 0, m_row = 0;
    int sh_mode = 0, sh_thr = 512, sh_me = 0, sh_cx = 0, sh_cy = 0;

    function automatic pix_t map_pix(input int g, input int col, input int row);
        pix_t p;
        int lo;
        p = '0;
        if (sh_me != 0 && ((sh_cx < H && col == sh_cx) || (sh_cy < V && row == sh_cy))) begin
            p.r = 1023; p.g = 0; p.b = 0;
            return p;
        end
        case (sh_mode)
            0: begin p.r = g; p.g = g; p.b = g; end
            1: begin p.r = 1023 - g; p.g = 1023 - g; p.b = 1023 - g; end
            2: begin
                lo = 2 * (g % 512);
                if (g < 512) begin p.r = 0; p.g = lo; p.b = 1022 - lo; end
                else         begin p.r = lo; p.g = 1022 - lo; p.b = 0; end
            end
            default: begin
                p.r = (g >= sh_thr) ? 1023 : 0;
                p.g = p.r;
                p.b = p.r;
            end
        endcase
        return p;
    endfunction

    always @(posedge iCLK or negedge iRST) begin
        int c, r;
        bit org;
        if (!iRST) begin
            m_col = 0; m_row = 0;
            sh_mode = 0; sh_thr = 512; sh_me = 0; sh_cx = 0; sh_cy = 0;
            p1 = '0;
            p2 = '0;
        end else begin
            if (p1.v) p2 = p1;
            else begin p2.v = 1'b0; p2.sof = 1'b0; end
            p1.v = 1'b0;
            p1.sof = 1'b0;
            c = iVS ? 0 : m_col;
            r = iVS ? 0 : m_row;
            if (iDVAL) begin
                org = (c == 0 && r == 0);
                if (org) begin
                    sh_mode = int'(iMODE); sh_thr = int'(iTHR); sh_me = int'(iMARK_EN);
                    sh_cx = int'(iCX); sh_cy = int'(iCY);
                end
                p1 = map_pix(int'(iDATA), c, r);
                p1.v = 1'b1;
                p1.sof = org;
                c++;
                if (c == H) begin
                    c = 0;
                    r++;
                    if (r == V) r = 0;
                end
                m_col = c;
                m_row = r;
            end else if (iVS) begin
                m_col = 0;
                m_row = 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge iCLK) begin
        n_checks++;
        if ({oDVAL, oSOF, oRed, oGreen, oBlue} !==
            {p2.v, p2.sof, p2.r[9:0], p2.g[9:0], p2.b[9:0]}) begin
            n_fail++;
            $display("FAIL model t=%0t got dval=%b sof=%b rgb=%0d,%0d,%0d want dval=%b sof=%b rgb=%0d,%0d,%0d",
                     $time, oDVAL, oSOF, oRed, oGreen, oBlue, p2.v, p2.sof, p2.r, p2.g, p2.b);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all start and end on a falling edge)
    // ------------------------------------------------------------------
    task automatic beat(input int g);
        iDVAL = 1'b1;
        iDATA = 10'(g);
        @(negedge iCLK);
        iDVAL = 1'b0;
        iVS   = 1'b0;
    endtask

    task automatic idle();
        iDVAL = 1'b0;
        @(negedge iCLK);
        iVS = 1'b0;
    endtask

    task automatic lit(input string name, input int r, input int g, input int b, input bit sof);
        n_checks++;
        if (oDVAL !== 1'b1 || oSOF !== sof || oRed !== 10'(r) || oGreen !== 10'(g) || oBlue !== 10'(b)) begin
            n_fail++;
            $display("FAIL %s got dval=%b sof=%b rgb=%0d,%0d,%0d want dval=1 sof=%b rgb=%0d,%0d,%0d",
                     name, oDVAL, oSOF, oRed, oGreen, oBlue, sof, r, g, b);
        end
    endtask

    task automatic chk_zero(input string name);
        n_checks++;
        if ({oDVAL, oSOF, oRed, oGreen, oBlue} !== 32'd0) begin
            n_fail++;
            $display("FAIL %s got dval=%b sof=%b rgb=%0d,%0d,%0d want all zero",
                     name, oDVAL, oSOF, oRed, oGreen, oBlue);
        end
    endtask

    // Stream random beats (with occasional gaps) until the next beat is (c,r)
    task automatic goto(input int c, input int r);
        int guard;
        guard = 0;
        while ((m_col != c || m_row != r) && guard < 2000) begin
            if ($urandom_range(0, 4) == 0) idle();
            beat(int'($urandom_range(0, 1023)));
            guard++;
        end
        if (m_col != c || m_row != r) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto got %0d,%0d want %0d,%0d", m_col, m_row, c, r);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        iRST = 1'b0;
        repeat (2) @(negedge iCLK);
        chk_zero("reset");
        iRST = 1'b1;

        // Mode 0
        beat(300); idle(); lit("m0_origin", 300, 300, 300, 1'b1);
        goto(5, 5); beat(300); idle(); lit("m0_5_5", 300, 300, 300, 1'b0);

        // Mode 2 heat
        iMODE = 2'd2; iVS = 1'b1;
        beat(256);  idle(); lit("heat_256", 0, 512, 510, 1'b1);
        beat(768);  idle(); lit("heat_768", 512, 510, 0, 1'b0);
        beat(1023); idle(); lit("heat_1023", 1022, 0, 0, 1'b0);
        beat(0);    idle(); lit("heat_0", 0, 0, 1022, 1'b0);

        // Mode 3 threshold, live threshold ignored mid-frame
        iMODE = 2'd3; iTHR = 10'd512; iVS = 1'b1;
        beat(511); idle(); lit("thr_511", 0, 0, 0, 1'b1);
        beat(512); idle(); lit("thr_512", 1023, 1023, 1023, 1'b0);
        iTHR = 10'd0;
        beat(511); idle(); lit("thr_shadow", 0, 0, 0, 1'b0);

        // Mode change takes effect only at the next origin beat
        iMODE = 2'd0; iTHR = 10'd512; iVS = 1'b1;
        beat(100); idle(); lit("m0_100", 100, 100, 100, 1'b1);
        iMODE = 2'd1;
        beat(100); idle(); lit("mode_hold", 100, 100, 100, 1'b0);
        goto(0, 0); beat(100); idle(); lit("inv_new_frame", 923, 923, 923, 1'b1);

        // Crosshair
        iMODE = 2'd0; iMARK_EN = 1'b1; iCX = 10'd10; iCY = 10'd20; iVS = 1'b1;
        beat(50); idle(); lit("mk_origin", 50, 50, 50, 1'b1);
        goto(10, 3);  beat(50); idle(); lit("mk_col", 1023, 0, 0, 1'b0);
        goto(4, 20);  beat(50); idle(); lit("mk_row", 1023, 0, 0, 1'b0);
        goto(11, 21); beat(50); idle(); lit("mk_off", 50, 50, 50, 1'b0);

        // Row line out of range
        iCY = 10'd30;
        goto(0, 0);   beat(60); idle(); lit("mk_cy_origin", 60, 60, 60, 1'b1);
        goto(3, 20);  beat(60); idle(); lit("mk_cy_suppressed", 60, 60, 60, 1'b0);
        goto(10, 21); beat(60); idle(); lit("mk_col_still", 1023, 0, 0, 1'b0);

        // iVS together with a beat at (7,3): restarts, next beat is column 1
        iCX = 10'd1;
        goto(7, 3); iVS = 1'b1;
        beat(200); idle(); lit("vs_beat", 200, 200, 200, 1'b1);
        beat(70);  idle(); lit("vs_next_col1", 1023, 0, 0, 1'b0);

        // iVS without a beat
        iMARK_EN = 1'b0;
        goto(5, 2); iVS = 1'b1; idle();
        beat(80); idle(); lit("vs_idle", 80, 80, 80, 1'b1);

        // Reset mid-frame
        goto(4, 2); beat(90);
        @(posedge iCLK);
        #1 iRST = 1'b0;
        #1 chk_zero("reset_mid");
        @(negedge iCLK);
        iRST = 1'b1;
        iMODE = 2'd1;
        beat(100); idle(); lit("post_reset", 923, 923, 923, 1'b1);

        repeat (3) idle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
